// File: rtl/pc_pkg.sv
// Shared definitions for the Hack program counter with return-address stack.
// Holds the operation-select encoding produced by the PC priority encoder and
// the default address width / stack depth shared with the CPU top level.
package pc_pkg;

    localparam int PC_WIDTH_DEFAULT = 16;
    localparam int PC_DEPTH_DEFAULT = 8;

    // One operation is selected per cycle; lower-priority requests are dropped.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_INCR = 3'd4
    } pc_op_e;

endpackage : pc_pkg

// File: rtl/ret_stack.sv
// Return-address LIFO.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (pointer only)
//   push, pop    : push push_data / drop top entry (caller guarantees legality
//                  and mutual exclusion)
//   push_data    : address to store
//   top          : entry at depth-1 (combinational read, zero when empty)
//   depth        : number of valid entries (registered)
//   full, empty  : decoded from depth
module ret_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [PW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    top_idx_s;

    // Stack pointer: only state that needs reset; contents are don't-care.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {PW{1'b0}};
        end else if (push) begin
            ptr_r <= ptr_r + PW'(1);
        end else if (pop) begin
            ptr_r <= ptr_r - PW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Entry storage, written at the current pointer on push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[ptr_r[IW-1:0]] <= push_data;
        end
    end

    // Combinational top-of-stack read; guarded so an empty stack never indexes
    // outside the array.
    always_comb begin
        top_idx_s = ptr_r - PW'(1);
        if (empty) begin
            top = {WIDTH{1'b0}};
        end else begin
            top = mem_r[top_idx_s[IW-1:0]];
        end
    end

    assign depth = ptr_r;
    assign full  = (ptr_r == PW'(DEPTH));
    assign empty = (ptr_r == {PW{1'b0}});

endmodule : ret_stack

// File: rtl/pc_call_stack.sv
// Hack program counter with hardware return-address stack.
// Drives the instruction ROM address (data_out) directly.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   load, call, ret, incr : PC operations, priority load > call > ret > incr
//   clr_err               : synchronous clear of the sticky error flags
//   data_in               : jump / call target
//   data_out              : current PC (registered)
//   depth                 : valid return-address entries
//   stack_full/empty      : decoded from depth
//   ovf_err / unf_err     : sticky call-while-full / ret-while-empty flags
module pc_call_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH_DEFAULT,
    parameter int               DEPTH        = PC_DEPTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       incr,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int PW = $clog2(DEPTH + 1);

    pc_op_e           op_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_next_s;
    logic [WIDTH-1:0] pc_plus1_s;
    logic [WIDTH-1:0] top_s;
    logic             push_s;
    logic             pop_s;
    logic             set_ovf_s;
    logic             set_unf_s;
    logic             ovf_r;
    logic             unf_r;

    assign pc_plus1_s = pc_r + WIDTH'(1);

    // Priority encoder: exactly one operation wins each cycle.
    always_comb begin
        op_s = OP_HOLD;
        if (load) begin
            op_s = OP_LOAD;
        end else if (call) begin
            op_s = OP_CALL;
        end else if (ret) begin
            op_s = OP_RET;
        end else if (incr) begin
            op_s = OP_INCR;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next-PC and stack control; an illegal call/ret is fully suppressed and
    // only raises its error flag.
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        set_ovf_s = 1'b0;
        set_unf_s = 1'b0;
        case (op_s)
            OP_LOAD: pc_next_s = data_in;
            OP_CALL: begin
                if (!stack_full) begin
                    push_s    = 1'b1;
                    pc_next_s = data_in;
                end else begin
                    set_ovf_s = 1'b1;
                end
            end
            OP_RET: begin
                if (!stack_empty) begin
                    pop_s     = 1'b1;
                    pc_next_s = top_s;
                end else begin
                    set_unf_s = 1'b1;
                end
            end
            OP_INCR: pc_next_s = pc_plus1_s;
            default: pc_next_s = pc_r;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_VECTOR;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Sticky error flags; a new error event outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            ovf_r <= set_ovf_s | (ovf_r & ~clr_err);
            unf_r <= set_unf_s | (unf_r & ~clr_err);
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_plus1_s),
        .top       (top_s),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign data_out = pc_r;
    assign ovf_err  = ovf_r;
    assign unf_err  = unf_r;

endmodule : pc_call_stack

// File: tb/tb_pc_call_stack.sv
// Directed self-checking bench for pc_call_stack (WIDTH=16, DEPTH=8).
module tb_pc_call_stack;

    logic        clk;
    logic        reset;
    logic        load;
    logic        incr;
    logic        call;
    logic        ret;
    logic        clr_err;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [3:0]  depth;
    logic        stack_full;
    logic        stack_empty;
    logic        ovf_err;
    logic        unf_err;

    int errors;
    int checks;

    pc_call_stack #(
        .WIDTH        (16),
        .DEPTH        (8),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .incr        (incr),
        .call        (call),
        .ret         (ret),
        .clr_err     (clr_err),
        .data_in     (data_in),
        .data_out    (data_out),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load = 1'b0; incr = 1'b0; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        data_in = 16'h0000;
        #2;
        checks++;
        if (data_out !== 16'h0000) begin
            errors++; $display("FAIL reset_pc got=%h exp=0000", data_out);
        end
        checks++;
        if (depth !== 4'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            errors++; $display("FAIL reset_depth got=%0d e=%b f=%b exp=0 1 0", depth, stack_empty, stack_full);
        end
        checks++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b%b exp=00", ovf_err, unf_err);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_incr();
        logic [15:0] exp_v;
        incr = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_v = 16'(i);
            checks++;
            if (data_out !== exp_v) begin
                errors++; $display("FAIL incr_%0d got=%h exp=%h", i, data_out, exp_v);
            end
        end
        incr = 1'b0; load = 1'b1; data_in = 16'hFFFF;
        tick();
        load = 1'b0; incr = 1'b1;
        tick();
        incr = 1'b0;
        checks++;
        if (data_out !== 16'h0000) begin
            errors++; $display("FAIL incr_wrap got=%h exp=0000", data_out);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; incr = 1'b1; data_in = 16'hFFA0;
        tick();
        checks++;
        if (data_out !== 16'hFFA0) begin
            errors++; $display("FAIL prio_load_incr got=%h exp=FFA0", data_out);
        end
        incr = 1'b0; call = 1'b1; data_in = 16'h0122;
        tick();
        idle();
        checks++;
        if (data_out !== 16'h0122 || depth !== 4'd0) begin
            errors++; $display("FAIL prio_load_call got=%h/%0d exp=0122/0", data_out, depth);
        end
    endtask

    task automatic test_nested();
        load = 1'b1; data_in = 16'h0010;
        tick();
        load = 1'b0; call = 1'b1; data_in = 16'h0100;
        tick();
        checks++;
        if (data_out !== 16'h0100 || depth !== 4'd1) begin
            errors++; $display("FAIL nest_call1 got=%h/%0d exp=0100/1", data_out, depth);
        end
        data_in = 16'h0200;
        tick();
        checks++;
        if (data_out !== 16'h0200 || depth !== 4'd2) begin
            errors++; $display("FAIL nest_call2 got=%h/%0d exp=0200/2", data_out, depth);
        end
        call = 1'b0; ret = 1'b1;
        tick();
        checks++;
        if (data_out !== 16'h0101 || depth !== 4'd1) begin
            errors++; $display("FAIL nest_ret1 got=%h/%0d exp=0101/1", data_out, depth);
        end
        tick();
        ret = 1'b0;
        checks++;
        if (data_out !== 16'h0011 || depth !== 4'd0 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL nest_ret2 got=%h/%0d/%b exp=0011/0/1", data_out, depth, stack_empty);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_v;
        load = 1'b1; data_in = 16'h0000;
        tick();
        load = 1'b0; call = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 16'((i + 1) * 256);
            tick();
        end
        checks++;
        if (stack_full !== 1'b1 || depth !== 4'd8 || data_out !== 16'h0800) begin
            errors++; $display("FAIL ovf_full got=%b/%0d/%h exp=1/8/0800", stack_full, depth, data_out);
        end
        data_in = 16'h0ABC;
        tick();
        call = 1'b0;
        checks++;
        if (data_out !== 16'h0800 || depth !== 4'd8 || ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_9th got=%h/%0d/%b exp=0800/8/1", data_out, depth, ovf_err);
        end
        ret = 1'b1;
        for (int j = 7; j >= 0; j--) begin
            tick();
            exp_v = (j == 0) ? 16'h0001 : 16'(j * 256 + 1);
            checks++;
            if (data_out !== exp_v || depth !== 4'(j)) begin
                errors++; $display("FAIL ovf_pop_%0d got=%h/%0d exp=%h/%0d", j, data_out, depth, exp_v, j);
            end
        end
        ret = 1'b0; clr_err = 1'b1;
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err);
        end
        tick();
        clr_err = 1'b0;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++; $display("FAIL ovf_clr got=%b exp=0", ovf_err);
        end
    endtask

    task automatic test_underflow();
        // PC is 0001 with an empty stack here.
        ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++;
        if (data_out !== 16'h0001 || unf_err !== 1'b1 || depth !== 4'd0) begin
            errors++; $display("FAIL unf_set got=%h/%b/%0d exp=0001/1/0", data_out, unf_err, depth);
        end
        clr_err = 1'b1;
        tick();
        checks++;
        if (unf_err !== 1'b0) begin
            errors++; $display("FAIL unf_clr got=%b exp=0", unf_err);
        end
        ret = 1'b1;
        tick();
        ret = 1'b0; clr_err = 1'b0;
        checks++;
        if (unf_err !== 1'b1 || data_out !== 16'h0001) begin
            errors++; $display("FAIL unf_clr_vs_set got=%b/%h exp=1/0001", unf_err, data_out);
        end
        // call and ret together: call wins, nothing popped.
        call = 1'b1; ret = 1'b1; data_in = 16'h0300;
        tick();
        idle();
        checks++;
        if (data_out !== 16'h0300 || depth !== 4'd1) begin
            errors++; $display("FAIL call_ret_same got=%h/%0d exp=0300/1", data_out, depth);
        end
        ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++;
        if (data_out !== 16'h0002 || depth !== 4'd0) begin
            errors++; $display("FAIL call_ret_pop got=%h/%0d exp=0002/0", data_out, depth);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; data_in = 16'h0040;
        tick();
        load = 1'b0; call = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 16'((i + 1) * 256);
            tick();
        end
        call = 1'b0;
        checks++;
        if (depth !== 4'd3) begin
            errors++; $display("FAIL ares_pre got=%0d exp=3", depth);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (data_out !== 16'h0000 || depth !== 4'd0 || stack_empty !== 1'b1 || unf_err !== 1'b0) begin
            errors++; $display("FAIL ares_async got=%h/%0d/%b/%b exp=0000/0/1/0", data_out, depth, stack_empty, unf_err);
        end
        tick();
        reset = 1'b0; ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++;
        if (unf_err !== 1'b1 || data_out !== 16'h0000) begin
            errors++; $display("FAIL ares_unf got=%b/%h exp=1/0000", unf_err, data_out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_incr();
        test_priority();
        test_nested();
        test_overflow();
        test_underflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_call_stack

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised Hack program counter with a hardware return-address stack.
- Keeps the existing PC controls (load, incr, reset) and adds call/return, giving subroutine linkage without RAM traffic.
- Sits between the CPU control decoder and the instruction ROM address bus.
- data_out drives the ROM address directly.

Parameters:
WIDTH, 16, PC / address width in bits.
DEPTH, 8, number of return-address entries; must be ≥ 2.
RESET_VECTOR, 0, PC value after reset.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  asynchronous, active-high reset.
load  input  1  jump: PC <= data_in.
incr  input  1  PC <= PC + 1.
call  input  1  push return address PC+1, then PC <= data_in.
ret  input  1  pop: PC <= top of stack.
clr_err  input  1  synchronous clear of the sticky error flags.
data_in  input  WIDTH  jump/call target.
data_out  output  WIDTH  current PC (registered).
depth  output  $clog2(DEPTH+1)  number of valid stack entries.
stack_full  output  1  depth == DEPTH (combinational from depth).
stack_empty  output  1  depth == 0 (combinational from depth).
ovf_err  output  1  sticky: a call was attempted while full.
unf_err  output  1  sticky: a ret was attempted while empty.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: on reset assertion, immediately and independent of clk:
  - data_out = RESET_VECTOR
  - depth = 0
  - ovf_err = 0, unf_err = 0
  - stack_empty = 1, stack_full = 0
  - Stack contents are don't-care.
- Reset has priority over everything.
- Priority at each rising edge with reset low: load > call > ret > incr > hold.
  - Exactly one operation executes per cycle; lower-priority requests that cycle are discarded, not queued.
- load: PC <= data_in. Stack unchanged.
- call, stack not full:
  - stack[depth] <= PC + 1 (mod 2^WIDTH)
  - depth <= depth + 1
  - PC <= data_in
- call, stack full:
  - Whole call suppressed: PC holds, stack and depth unchanged.
  - ovf_err <= 1.
- ret, stack not empty:
  - PC <= stack[depth-1]
  - depth <= depth - 1
- ret, stack empty:
  - PC holds.
  - unf_err <= 1.
- incr: PC <= PC + 1, wrapping from 2^WIDTH-1 to 0. No flag.
- Neither call nor ret is asserted together with load in normal use; if it is, load wins and the stack is untouched.
- call and ret in the same cycle: call wins, no pop.
- Latency:
  - All PC/depth updates are visible on data_out/depth one cycle after the sampling edge.
  - Full/empty flags follow depth combinationally, in the same cycle.
- Error flags:
  - Sticky until clr_err or reset.
  - clr_err clears both flags at the edge.
  - If clr_err coincides with a new error event, the new event wins (flag set).
- A popped entry may equal any value, including RESET_VECTOR; no special handling.
- Reset asserted mid-sequence (e.g. with nested calls outstanding) discards all stack state; the next ret after reset is an underflow.

Decomposition:
- Shared package (pc_pkg):
  - Operation-select encoding constants: OP_HOLD, OP_LOAD, OP_CALL, OP_RET, OP_INCR, produced by a priority encoder in the top.
  - Default WIDTH/DEPTH constants shared with the CPU top.
- One sub-module, ret_stack:
  - LIFO with push, pop, push_data, top, depth, full, empty; asynchronous active-high reset of the pointer only.
  - Registers the pointer; reads top combinationally.
  - Suppression on full/empty is decided in pc_call_stack, not in ret_stack.

Test Plan:
- Reset/incr: hold reset, check data_out=0000 immediately without a clock edge; release, incr=1 for 3 cycles -> data_out 0001, 0002, 0003; load FFFF then incr -> 0000 (wrap).
- Priority: load=1, incr=1, data_in=FFA0 -> data_out=FFA0; load=1, call=1, data_in=0122 -> data_out=0122, depth stays 0.
- Nested call/ret: PC=0010, call 0100; at PC=0100 call 0200; ret -> 0101; ret -> 0011; depth 1, 2, 1, 0; stack_empty=1 at end.
- Overflow: 8 calls (DEPTH=8) -> stack_full=1; 9th call with data_in=0ABC -> PC unchanged, depth=8, ovf_err=1; 8 rets restore the addresses in LIFO order.
- Underflow and clear: ret with empty stack -> PC holds, unf_err=1; clr_err -> 0 next cycle; clr_err together with ret on empty -> unf_err stays 1.
- Async reset mid-operation: depth=3, assert reset between edges -> data_out=0000 and depth=0 before the next edge; first ret after release -> unf_err=1.
